// File: rtl/reg_scoreboard_pkg.sv
// Shared widths and drain FSM encoding for the
// register write scoreboard.
package reg_scoreboard_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } sb_state_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: per-register 2-bit counters gate
// ID issue on read-after-write hazards, with a drain handshake.
module reg_scoreboard
   import reg_scoreboard_pkg::*;
#(
   parameter bit LOAD_ONLY = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic                  id_is_load,
   input  logic                  id_read_en_1,
   input  logic                  id_read_en_2,
   input  logic [REG_ADDR_W-1:0] id_addr_1,
   input  logic [REG_ADDR_W-1:0] id_addr_2,
   input  logic                  id_write_en,
   input  logic [REG_ADDR_W-1:0] id_write_addr,
   input  logic                  wb_en,
   input  logic [REG_ADDR_W-1:0] wb_addr,
   input  logic                  drain_req,
   output logic                  drain_done,
   output logic                  stall_req,
   output logic                  issue,
   output logic                  busy,
   output logic                  err
);

   logic [1:0] cnt [NUM_REGS];

   logic      tracked;
   logic      hazard;
   logic      full;
   logic      wb_live;
   logic      wb_miss;

   sb_state_e state_q, state_d;
   logic      drain_done_q, drain_done_d;
   logic      err_q, err_d;

   assign cnt[0] = 2'd0;

   assign tracked = id_write_en
                 && (id_write_addr != REG_ZERO)
                 && (id_is_load || !LOAD_ONLY);

   // Registered counts only: a same-cycle writeback does not release.
   assign hazard = (id_read_en_1 && (id_addr_1 != REG_ZERO)
                    && (cnt[id_addr_1] != 2'd0))
                || (id_read_en_2 && (id_addr_2 != REG_ZERO)
                    && (cnt[id_addr_2] != 2'd0));

   assign full = tracked && (cnt[id_write_addr] == 2'd3);

   assign issue = id_valid && (state_q == ST_RUN)
               && !hazard && !full;

   assign stall_req = id_valid && !issue;

   assign wb_live = wb_en && (wb_addr != REG_ZERO);
   assign wb_miss = wb_live && (cnt[wb_addr] == 2'd0);

   for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
      logic [1:0] cnt_q, cnt_d;
      logic       inc, dec;

      always_comb begin
         inc   = issue && tracked
              && (id_write_addr == REG_ADDR_W'(i));
         dec   = wb_live && (wb_addr == REG_ADDR_W'(i))
              && (cnt_q != 2'd0);
         cnt_d = cnt_q;
         if (inc && !dec) begin
            cnt_d = cnt_q + 2'd1;
         end else if (dec && !inc) begin
            cnt_d = cnt_q - 2'd1;
         end
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            cnt_q <= 2'd0;
         end else begin
            cnt_q <= cnt_d;
         end
      end

      assign cnt[i] = cnt_q;
   end

   always_comb begin
      busy = 1'b0;
      for (int i = 1; i < NUM_REGS; i++) begin
         busy = busy | (cnt[i] != 2'd0);
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_RUN: begin
            if (drain_req) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!drain_req) begin
               state_d = ST_RUN;
            end else if (!busy) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (!drain_req) state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
      drain_done_d = (state_d == ST_DONE);
      err_d        = err_q | wb_miss;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_RUN;
         drain_done_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         drain_done_q <= drain_done_d;
         err_q        <= err_d;
      end
   end

   assign drain_done = drain_done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Random and directed checks of reg_scoreboard against an
// array-based model, for both LOAD_ONLY settings.
module tb_reg_scoreboard;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       id_valid, id_is_load;
   logic       id_read_en_1, id_read_en_2;
   logic [4:0] id_addr_1, id_addr_2;
   logic       id_write_en;
   logic [4:0] id_write_addr;
   logic       wb_en;
   logic [4:0] wb_addr;
   logic       drain_req;
   logic [1:0] drain_done, stall_req, issue, busy, err;

   int n_chk  = 0;
   int n_fail = 0;

   // index 0: LOAD_ONLY=0, index 1: LOAD_ONLY=1
   int m_cnt [2][32];
   bit m_err [2];
   int m_st  [2];
   bit chk_on = 1'b0;

   always #5 clk = ~clk;

   reg_scoreboard #(.LOAD_ONLY(1'b0)) u_all (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_is_load(id_is_load),
      .id_read_en_1(id_read_en_1), .id_read_en_2(id_read_en_2),
      .id_addr_1(id_addr_1), .id_addr_2(id_addr_2),
      .id_write_en(id_write_en), .id_write_addr(id_write_addr),
      .wb_en(wb_en), .wb_addr(wb_addr),
      .drain_req(drain_req), .drain_done(drain_done[0]),
      .stall_req(stall_req[0]), .issue(issue[0]),
      .busy(busy[0]), .err(err[0])
   );

   reg_scoreboard #(.LOAD_ONLY(1'b1)) u_ld (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_is_load(id_is_load),
      .id_read_en_1(id_read_en_1), .id_read_en_2(id_read_en_2),
      .id_addr_1(id_addr_1), .id_addr_2(id_addr_2),
      .id_write_en(id_write_en), .id_write_addr(id_write_addr),
      .wb_en(wb_en), .wb_addr(wb_addr),
      .drain_req(drain_req), .drain_done(drain_done[1]),
      .stall_req(stall_req[1]), .issue(issue[1]),
      .busy(busy[1]), .err(err[1])
   );

   task automatic check(input string nm, input logic act,
                        input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0b expected %0b at %0t",
                  nm, act, exp, $time);
      end
   endtask

   task automatic check_int(input string nm, input int act,
                            input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic bit m_busy(input int k);
      for (int r = 1; r < 32; r++) begin
         if (m_cnt[k][r] != 0) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic bit m_tracked(input int k);
      return id_write_en && (id_write_addr != 0)
          && (id_is_load || (k == 0));
   endfunction

   function automatic bit m_issue(input int k);
      bit hz;
      bit fl;
      hz = (id_read_en_1 && id_addr_1 != 0
            && m_cnt[k][id_addr_1] != 0)
        || (id_read_en_2 && id_addr_2 != 0
            && m_cnt[k][id_addr_2] != 0);
      fl = m_tracked(k) && (m_cnt[k][id_write_addr] == 3);
      return id_valid && (m_st[k] == 0) && !hz && !fl;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int r = 0; r < 32; r++) m_cnt[k][r] = 0;
         m_err[k] = 1'b0;
         m_st[k]  = 0;
      end
   endtask

   task automatic model_step();
      bit iss [2];
      bit tr  [2];
      bit bz  [2];
      for (int k = 0; k < 2; k++) begin
         iss[k] = m_issue(k);
         tr[k]  = m_tracked(k);
         bz[k]  = m_busy(k);
      end
      for (int k = 0; k < 2; k++) begin
         if (wb_en && wb_addr != 0) begin
            if (m_cnt[k][wb_addr] == 0) m_err[k] = 1'b1;
            else m_cnt[k][wb_addr] -= 1;
         end
         if (iss[k] && tr[k]) m_cnt[k][id_write_addr] += 1;
         case (m_st[k])
            0: if (drain_req) m_st[k] = 1;
            1: begin
               if (!drain_req) m_st[k] = 0;
               else if (!bz[k]) m_st[k] = 2;
            end
            default: if (!drain_req) m_st[k] = 0;
         endcase
      end
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) model_reset();
         else model_step();
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (chk_on) begin
            for (int k = 0; k < 2; k++) begin
               check($sformatf("issue[%0d]", k),
                     issue[k], m_issue(k));
               check($sformatf("stall_req[%0d]", k),
                     stall_req[k], id_valid && !m_issue(k));
               check($sformatf("busy[%0d]", k),
                     busy[k], m_busy(k));
               check($sformatf("err[%0d]", k),
                     err[k], m_err[k]);
               check($sformatf("drain_done[%0d]", k),
                     drain_done[k], m_st[k] == 2);
            end
         end
      end
   end

   task automatic idle();
      id_valid      = 1'b0;
      id_is_load    = 1'b0;
      id_read_en_1  = 1'b0;
      id_read_en_2  = 1'b0;
      id_addr_1     = 5'd0;
      id_addr_2     = 5'd0;
      id_write_en   = 1'b0;
      id_write_addr = 5'd0;
      wb_en         = 1'b0;
      wb_addr       = 5'd0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic load(input logic [4:0] a);
      idle();
      id_valid      = 1'b1;
      id_is_load    = 1'b1;
      id_write_en   = 1'b1;
      id_write_addr = a;
   endtask

   task automatic rd(input logic [4:0] a);
      idle();
      id_valid     = 1'b1;
      id_read_en_1 = 1'b1;
      id_addr_1    = a;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      drain_req = 1'b0;
      idle();
      step();
      rst = 1'b1;
   endtask

   logic [4:0] pend [$];

   initial begin
      idle();
      drain_req = 1'b0;
      id_valid  = 1'b1;
      chk_on    = 1'b1;
      at_neg();
      check("rst_issue_follows", issue[1], 1'b1);
      check("rst_busy", busy[1], 1'b0);
      check("rst_drain_done", drain_done[1], 1'b0);
      check("rst_err", err[0], 1'b0);
      step();
      rst = 1'b1;

      // load-use
      load(5);
      at_neg();
      check("lu_issue_lw", issue[1], 1'b1);
      step();
      rd(5);
      id_write_en   = 1'b1;
      id_write_addr = 5'd3;
      repeat (3) begin
         at_neg();
         check("lu_stall", stall_req[1], 1'b1);
         step();
      end
      wb_en   = 1'b1;
      wb_addr = 5'd5;
      at_neg();
      check("lu_stall_wb_cycle", stall_req[1], 1'b1);
      step();
      wb_en = 1'b0;
      at_neg();
      check("lu_issue_after_wb", issue[1], 1'b1);
      check("lu_issue_after_wb_all", issue[0], 1'b1);
      step();
      idle();
      step();
      do_reset();

      // ALU write then read
      idle();
      id_valid      = 1'b1;
      id_write_en   = 1'b1;
      id_write_addr = 5'd6;
      at_neg();
      check("alu_issue", issue[1], 1'b1);
      step();
      rd(6);
      at_neg();
      check("alu_nostall_lo1", stall_req[1], 1'b0);
      check("alu_stall_lo0", stall_req[0], 1'b1);
      check_int("m_cnt1_6", m_cnt[1][6], 0);
      check_int("m_cnt0_6", m_cnt[0][6], 1);
      step();
      wb_en   = 1'b1;
      wb_addr = 5'd6;
      at_neg();
      check("alu_stall_wb_cycle", stall_req[0], 1'b1);
      step();
      wb_en = 1'b0;
      at_neg();
      check("alu_issue_lo0", issue[0], 1'b1);
      check("miss_err_lo1", err[1], 1'b1);
      check("no_err_lo0", err[0], 1'b0);
      step();
      idle();
      repeat (3) step();
      at_neg();
      check("err_sticky_lo1", err[1], 1'b1);
      step();
      do_reset();

      // counter saturation at three
      repeat (3) begin
         load(7);
         at_neg();
         check("three_ld_issue", issue[1], 1'b1);
         step();
      end
      check_int("cnt7_three", m_cnt[1][7], 3);
      at_neg();
      check("fourth_ld_stall", stall_req[1], 1'b1);
      check("fourth_ld_stall_lo0", stall_req[0], 1'b1);
      step();
      wb_en   = 1'b1;
      wb_addr = 5'd7;
      at_neg();
      check("full_wb_cycle_stall", stall_req[1], 1'b1);
      step();
      at_neg();
      check("ld_wb_same_issue", issue[1], 1'b1);
      step();
      check_int("cnt7_same_cycle", m_cnt[1][7], 2);
      wb_en = 1'b0;
      at_neg();
      check("ld_to_three", issue[1], 1'b1);
      step();
      at_neg();
      check("full_again", stall_req[1], 1'b1);
      step();
      idle();
      step();
      do_reset();

      // register zero
      idle();
      id_valid      = 1'b1;
      id_is_load    = 1'b1;
      id_write_en   = 1'b1;
      id_read_en_1  = 1'b1;
      wb_en         = 1'b1;
      repeat (2) begin
         at_neg();
         check("r0_issue", issue[1], 1'b1);
         check("r0_issue_lo0", issue[0], 1'b1);
         step();
      end
      idle();
      at_neg();
      check("r0_busy", busy[1], 1'b0);
      check("r0_err", err[1], 1'b0);
      check_int("m_cnt1_0", m_cnt[1][0], 0);
      step();
      wb_en   = 1'b1;
      wb_addr = 5'd9;
      step();
      wb_en = 1'b0;
      at_neg();
      check("wb9_err", err[1], 1'b1);
      check("wb9_err_lo0", err[0], 1'b1);
      step();
      repeat (2) step();
      at_neg();
      check("wb9_err_sticky", err[0], 1'b1);
      step();
      do_reset();

      // drain with two loads pending
      load(5);
      step();
      load(8);
      step();
      idle();
      drain_req = 1'b1;
      at_neg();
      check("pre_drain_busy", busy[1], 1'b1);
      step();
      id_valid = 1'b1;
      at_neg();
      check("drain_blocks_issue", issue[1], 1'b0);
      check("drain_stall", stall_req[1], 1'b1);
      step();
      wb_en   = 1'b1;
      wb_addr = 5'd5;
      step();
      wb_addr = 5'd8;
      at_neg();
      check("drain_done_low", drain_done[1], 1'b0);
      step();
      wb_en = 1'b0;
      at_neg();
      check("drain_busy_zero", busy[1], 1'b0);
      check("drain_done_wait", drain_done[1], 1'b0);
      step();
      at_neg();
      check("drain_done_hi", drain_done[1], 1'b1);
      check("done_blocks_issue", issue[1], 1'b0);
      step();
      drain_req = 1'b0;
      at_neg();
      check("done_holds", drain_done[1], 1'b1);
      step();
      at_neg();
      check("back_run_done0", drain_done[1], 1'b0);
      check("back_run_issue", issue[1], 1'b1);
      step();
      drain_req = 1'b1;
      step();
      drain_req = 1'b0;
      at_neg();
      check("drain_abort_block", issue[1], 1'b0);
      step();
      at_neg();
      check("drain_abort_run", issue[1], 1'b1);
      step();

      // asynchronous reset mid-drain
      load(5);
      step();
      step();
      idle();
      drain_req = 1'b1;
      step();
      step();
      check_int("cnt5_two", m_cnt[1][5], 2);
      rst = 1'b0;
      rd(5);
      #2;
      check("async_busy", busy[1], 1'b0);
      check("async_busy_lo0", busy[0], 1'b0);
      check("async_drain_done", drain_done[1], 1'b0);
      check("async_issue", issue[1], 1'b1);
      drain_req = 1'b0;
      idle();
      step();
      rst = 1'b1;

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         if (i == 400) begin
            step();
            do_reset();
         end
         idle();
         id_valid      = ($urandom_range(0, 3) != 0);
         id_is_load    = ($urandom_range(0, 1) == 1);
         id_read_en_1  = ($urandom_range(0, 1) == 1);
         id_read_en_2  = ($urandom_range(0, 1) == 1);
         id_addr_1     = 5'($urandom_range(0, 7));
         id_addr_2     = 5'($urandom_range(0, 7));
         id_write_en   = ($urandom_range(0, 3) != 0);
         id_write_addr = 5'($urandom_range(0, 7));
         pend.delete();
         for (int r = 1; r < 32; r++) begin
            if (m_cnt[1][r] != 0) pend.push_back(5'(r));
         end
         if (pend.size() > 0 && $urandom_range(0, 2) != 0) begin
            wb_en   = 1'b1;
            wb_addr = pend[$urandom_range(0, pend.size() - 1)];
         end else if ($urandom_range(0, 19) == 0) begin
            wb_en   = 1'b1;
            wb_addr = 5'($urandom_range(0, 7));
         end
         if ($urandom_range(0, 29) == 0) drain_req = !drain_req;
         step();
      end

      idle();
      drain_req = 1'b0;
      step();
      chk_on = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
